// File: rtl/note_synth_pkg.sv
// Shared constants and types for the polyphonic square-wave synthesiser.
// Holds the default tone table and the mix saturation helper.
package note_synth_pkg;

  localparam int unsigned NUM_VOICES = 6;
  localparam int unsigned LEVEL_W    = 4;
  localparam int unsigned SAMPLE_W   = 32;
  localparam int unsigned CNT_W      = 19;
  localparam int unsigned MIX_W      = 35;

  typedef logic [CNT_W-1:0]           half_period_t;
  typedef half_period_t [NUM_VOICES-1:0] half_period_tbl_t;
  typedef logic [LEVEL_W-1:0]         level_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // C4..A4 at 50 MHz, voice 0 in the least significant slot.
  localparam half_period_tbl_t HALF_PERIOD = {
    19'd56818, 19'd63776, 19'd71586, 19'd75843, 19'd85131, 19'd95556
  };

  // Clamp the wide accumulator to the sample range; overflow shows as disagreeing top bits.
  function automatic sample_t saturate(input logic [MIX_W-1:0] acc);
    logic [MIX_W-SAMPLE_W:0] top;
    top = acc[MIX_W-1:SAMPLE_W-1];
    if (top == '0 || top == '1) begin
      return sample_t'(acc[SAMPLE_W-1:0]);
    end else if (acc[MIX_W-1]) begin
      return sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}});
    end else begin
      return sample_t'({1'b0, {(SAMPLE_W-1){1'b1}}});
    end
  endfunction

endpackage

// File: rtl/note_synth_if.sv
// Gate/codec bundle between key input, synthesiser and the codec output FIFO.
// master = synthesiser side, slave = keys plus codec side.
interface note_synth_if;
  import note_synth_pkg::*;

  logic [NUM_VOICES-1:0] gate;
  logic                  audio_out_allowed;
  sample_t               left_out;
  sample_t               right_out;
  logic                  write_audio_out;
  logic                  active;
  logic                  overrun;

  modport master (
    input  gate,
    input  audio_out_allowed,
    output left_out,
    output right_out,
    output write_audio_out,
    output active,
    output overrun
  );

  modport slave (
    output gate,
    output audio_out_allowed,
    input  left_out,
    input  right_out,
    input  write_audio_out,
    input  active,
    input  overrun
  );

endinterface

// File: rtl/note_synth_voice.sv
// One voice: free-running tone divider, square phase and 4-bit linear envelope.
// Produces a signed sample of +/-(level * AMP_STEP).
module note_synth_voice
  import note_synth_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] AMP_STEP = 32'd1125000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         gate_i,
  input  logic         env_tick_i,
  input  half_period_t half_period_i,
  output sample_t      sample_o,
  output level_t       level_o
);

  half_period_t        cnt_q, cnt_d;
  logic                phase_q, phase_d;
  level_t              level_q, level_d;
  logic [SAMPLE_W-1:0] mag;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    level_d = level_q;
    // Tone keeps running through the release tail so the decay stays audible.
    if (gate_i || level_q != '0) begin
      if (cnt_q == half_period_i) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
    if (env_tick_i) begin
      if (gate_i && level_q != '1) begin
        level_d = level_q + 1'b1;
      end else if (!gate_i && level_q != '0) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      level_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      level_q <= level_d;
    end
  end

  assign mag      = AMP_STEP * SAMPLE_W'(level_q);
  assign sample_o = phase_q ? $signed(mag) : -$signed(mag);
  assign level_o  = level_q;

endmodule

// File: rtl/note_synth.sv
// Polyphonic synthesiser top: voices, saturating mixer, sample/envelope prescalers
// and the single-entry pending sample feeding the codec write handshake.
module note_synth
  import note_synth_pkg::*;
#(
  parameter int unsigned         SAMPLE_DIV      = 1042,
  parameter int unsigned         ENV_DIV         = 65536,
  parameter logic [SAMPLE_W-1:0] AMP_STEP        = 32'd1125000,
  parameter half_period_tbl_t    HALF_PERIOD_TBL = HALF_PERIOD
) (
  input logic         clock,
  input logic         resetn,
  note_synth_if.master codec_io
);

  localparam int unsigned SampleCntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned EnvCntW    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  logic [SampleCntW-1:0] sample_cnt_q, sample_cnt_d;
  logic [EnvCntW-1:0]    env_cnt_q, env_cnt_d;
  logic                  strobe, env_tick, push;
  logic [MIX_W-1:0]      acc;

  sample_t sample_q, sample_d;
  logic    pending_q, pending_d;
  logic    write_q, write_d;
  logic    overrun_q, overrun_d;
  logic    active_q, active_d;

  sample_t voice_sample [NUM_VOICES];
  level_t  voice_level  [NUM_VOICES];

  assign strobe   = (sample_cnt_q == SampleCntW'(SAMPLE_DIV - 1));
  assign env_tick = (env_cnt_q == EnvCntW'(ENV_DIV - 1));

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    note_synth_voice #(
      .AMP_STEP (AMP_STEP)
    ) u_voice (
      .clock         (clock),
      .resetn        (resetn),
      .gate_i        (codec_io.gate[v]),
      .env_tick_i    (env_tick),
      .half_period_i (HALF_PERIOD_TBL[v]),
      .sample_o      (voice_sample[v]),
      .level_o       (voice_level[v])
    );
  end

  always_comb begin
    acc = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      acc = acc + {{(MIX_W-SAMPLE_W){voice_sample[v][SAMPLE_W-1]}}, voice_sample[v]};
    end
  end

  always_comb begin
    sample_cnt_d = strobe ? '0 : sample_cnt_q + 1'b1;
    env_cnt_d    = env_tick ? '0 : env_cnt_q + 1'b1;
    push         = pending_q & codec_io.audio_out_allowed;
    write_d      = push;
    // A capture coinciding with a push refills the slot instead of counting as an overrun.
    pending_d    = strobe | (pending_q & ~push);
    overrun_d    = overrun_q | (strobe & pending_q & ~push);
    sample_d     = strobe ? saturate(acc) : sample_q;
    active_d     = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      active_d = active_d | (voice_level[v] != '0);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sample_cnt_q <= '0;
      env_cnt_q    <= '0;
      sample_q     <= '0;
      pending_q    <= 1'b0;
      write_q      <= 1'b0;
      overrun_q    <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      env_cnt_q    <= env_cnt_d;
      sample_q     <= sample_d;
      pending_q    <= pending_d;
      write_q      <= write_d;
      overrun_q    <= overrun_d;
      active_q     <= active_d;
    end
  end

  assign codec_io.left_out        = sample_q;
  assign codec_io.right_out       = sample_q;
  assign codec_io.write_audio_out = write_q;
  assign codec_io.overrun         = overrun_q;
  assign codec_io.active          = active_q;

endmodule

// File: tb/tb_note_synth.sv
// Bench for note_synth: two instances (nominal and saturating amplitude) checked every
// cycle against a behavioural model, plus directed checks of the key scenarios.
module tb_note_synth;

  localparam int  SDIV  = 8;
  localparam int  EDIV  = 4;
  localparam int  NV    = 6;
  localparam longint AMP_A = 1125000;
  localparam longint AMP_B = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  note_synth_if bus_a ();
  note_synth_if bus_b ();

  note_synth #(
    .SAMPLE_DIV      (SDIV),
    .ENV_DIV         (EDIV),
    .AMP_STEP        (32'd1125000),
    .HALF_PERIOD_TBL ({19'd8, 19'd7, 19'd6, 19'd5, 19'd4, 19'd3})
  ) dut (
    .clock    (clk),
    .resetn   (resetn),
    .codec_io (bus_a)
  );

  note_synth #(
    .SAMPLE_DIV      (SDIV),
    .ENV_DIV         (EDIV),
    .AMP_STEP        (32'h7FFF_FFFF),
    .HALF_PERIOD_TBL ({19'd8, 19'd7, 19'd6, 19'd5, 19'd4, 19'd3})
  ) dut_sat (
    .clock    (clk),
    .resetn   (resetn),
    .codec_io (bus_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [5:0] gate_v;
  logic       allowed_v;

  // Reference state: plain integers per voice plus the output slot.
  int hp [NV] = '{3, 4, 5, 6, 7, 8};
  int m_cnt [NV];
  int m_ph  [NV];
  int m_lvl [NV];
  int ncyc;
  int m_sample [2];
  bit m_pending, m_write, m_overrun, m_active;

  task automatic drive(input logic [5:0] g, input logic a);
    gate_v = g;
    allowed_v = a;
    bus_a.gate = g;
    bus_b.gate = g;
    bus_a.audio_out_allowed = a;
    bus_b.audio_out_allowed = a;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_cnt[v] = 0;
      m_ph[v]  = 0;
      m_lvl[v] = 0;
    end
    ncyc = 0;
    m_sample[0] = 0;
    m_sample[1] = 0;
    m_pending = 0;
    m_write = 0;
    m_overrun = 0;
    m_active = 0;
  endtask

  function automatic int mix(input longint amp);
    longint s;
    bit [31:0] mag;
    int sv;
    s = 0;
    for (int v = 0; v < NV; v++) begin
      mag = 32'(longint'(m_lvl[v]) * amp);
      sv  = (m_ph[v] != 0) ? int'(mag) : -int'(mag);
      s   = s + longint'(sv);
    end
    if (s > 64'sd2147483647) return 2147483647;
    if (s < -64'sd2147483648) return int'(32'h8000_0000);
    return int'(s);
  endfunction

  // Apply one clock edge to the model using the inputs stable before the edge.
  task automatic model_edge();
    bit tick_e, strobe, push, g;
    int mix_a, mix_b;
    if (!resetn) begin
      model_reset();
      return;
    end
    tick_e = (ncyc % EDIV) == EDIV - 1;
    strobe = (ncyc % SDIV) == SDIV - 1;
    ncyc++;
    mix_a = mix(AMP_A);
    mix_b = mix(AMP_B);
    push = m_pending && allowed_v;
    m_overrun = m_overrun || (strobe && m_pending && !push);
    m_write = push;
    m_pending = strobe || (m_pending && !push);
    if (strobe) begin
      m_sample[0] = mix_a;
      m_sample[1] = mix_b;
    end
    m_active = 0;
    for (int v = 0; v < NV; v++) if (m_lvl[v] != 0) m_active = 1;
    for (int v = 0; v < NV; v++) begin
      g = gate_v[v];
      if (g || m_lvl[v] != 0) begin
        if (m_cnt[v] == hp[v]) begin
          m_cnt[v] = 0;
          m_ph[v]  = 1 - m_ph[v];
        end else begin
          m_cnt[v]++;
        end
      end else begin
        m_cnt[v] = 0;
        m_ph[v]  = 0;
      end
      if (tick_e) begin
        if (g && m_lvl[v] < 15) m_lvl[v]++;
        else if (!g && m_lvl[v] > 0) m_lvl[v]--;
      end
    end
  endtask

  task automatic compare_all();
    check("left_a", bus_a.left_out, m_sample[0]);
    check("right_a", bus_a.right_out, m_sample[0]);
    check("left_sat", bus_b.left_out, m_sample[1]);
    check("right_sat", bus_b.right_out, m_sample[1]);
    check("write_a", bus_a.write_audio_out, m_write);
    check("write_sat", bus_b.write_audio_out, m_write);
    check("active", bus_a.active, m_active);
    check("overrun_a", bus_a.overrun, m_overrun);
    check("overrun_sat", bus_b.overrun, m_overrun);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int wcount, hold;
    longint lv, max_abs;
    bit seen_sat;

    drive(6'h00, 1'b1);
    model_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1 compare_all();
    tick();
    tick();
    #2 resetn = 1'b1;

    // Idle: one write every sample period, silent output.
    wcount = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      wcount += int'(bus_a.write_audio_out);
    end
    check("idle_writes", wcount, 12);
    check("idle_left", bus_a.left_out, 0);
    check("idle_active", bus_a.active, 0);

    // Attack on voice 0 up to full level.
    drive(6'h01, 1'b1);
    for (int i = 0; i < 70; i++) tick();
    lv = bus_a.left_out;
    check("v0_full_amp", (lv < 0) ? -lv : lv, 16875000);
    check("v0_active", bus_a.active, 1);

    // Release back to silence.
    drive(6'h00, 1'b1);
    for (int i = 0; i < 70; i++) tick();
    check("rel_active", bus_a.active, 0);
    check("rel_left", bus_a.left_out, 0);

    // All voices: bounded mix on the nominal instance, clamping on the saturating one.
    drive(6'h3F, 1'b1);
    max_abs = 0;
    seen_sat = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      lv = bus_a.left_out;
      if (lv < 0) lv = -lv;
      if (lv > max_abs) max_abs = lv;
      if (bus_b.left_out == 32'sh7FFF_FFFF || bus_b.left_out == 32'sh8000_0000) seen_sat = 1;
    end
    check("mix_bound", max_abs <= 101250000, 1);
    check("sat_seen", seen_sat, 1);
    check("all_no_overrun", bus_a.overrun, 0);

    // Backpressure: no writes, overrun latches, one write once allowed returns.
    drive(6'h3F, 1'b0);
    wcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      wcount += int'(bus_a.write_audio_out);
    end
    check("bp_writes", wcount, 0);
    check("bp_overrun", bus_a.overrun, 1);
    drive(6'h3F, 1'b1);
    tick();
    check("bp_release_write", bus_a.write_audio_out, 1);

    // Asynchronous reset mid-tone, asserted away from any clock edge.
    for (int i = 0; i < 13; i++) tick();
    #2 resetn = 1'b0;
    #1 model_reset();
    compare_all();
    check("rst_left", bus_a.left_out, 0);
    check("rst_overrun", bus_a.overrun, 0);
    tick();
    #2 resetn = 1'b1;
    wcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      wcount += int'(bus_a.write_audio_out);
    end
    check("post_rst_quiet", wcount, 0);
    tick();
    check("post_rst_first_write", bus_a.write_audio_out, 1);

    // Randomised gates and backpressure.
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        drive(6'($urandom_range(0, 63)), $urandom_range(0, 4) != 0);
        hold = $urandom_range(1, 12);
      end
      hold--;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
